// File: rtl/wm_front_panel.sv
// Washing-machine front panel: coin credit, lid debounce and double-wash latch,
// then a start handshake on C and progress tracking through the washer's stage lamps.
module wm_front_panel #(
    parameter int PRICE      = 3,
    parameter int CW         = 3,
    parameter int DEB_CYCLES = 4,
    parameter int START_TMO  = 15
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          COIN_IN,
    input  logic          DW_BTN,
    input  logic          REFUND_BTN,
    input  logic          LID_SW,
    input  logic [7:0]    LAMPS,
    output logic          C,
    output logic          L,
    output logic          DW,
    output logic [CW-1:0] CREDIT,
    output logic          BUSY,
    output logic          REFUND,
    output logic          DONE,
    output logic          FAULT
);
    typedef enum logic [1:0] {P_COLLECT = 2'd0, P_START = 2'd1, P_RUN = 2'd2} state_e;

    localparam logic [CW-1:0] PRICE_C  = CW'(PRICE);
    localparam logic [3:0]    DEB_LAST = 4'(DEB_CYCLES - 1);
    localparam logic [7:0]    TMO_LAST = 8'(START_TMO - 1);

    state_e        state_q, state_d;
    logic [2:0]    coin_s_q, dwb_s_q, refb_s_q;
    logic [1:0]    lid_s_q;
    logic [3:0]    deb_cnt_q, deb_cnt_d;
    logic [7:0]    tmo_cnt_q, tmo_cnt_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          l_q, l_d, dw_q, dw_d, c_q, c_d, busy_q, busy_d;
    logic          refund_q, refund_d, done_q, done_d, fault_q, fault_d;
    logic          coin_edge, dw_edge, ref_edge;
    logic          unused_lamps;

    assign coin_edge    = coin_s_q[1] & ~coin_s_q[2];
    assign dw_edge      = dwb_s_q[1]  & ~dwb_s_q[2];
    assign ref_edge     = refb_s_q[1] & ~refb_s_q[2];
    assign unused_lamps = ^LAMPS[7:2];

    // State register plus every registered output and counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= P_COLLECT;
            coin_s_q  <= '0;
            dwb_s_q   <= '0;
            refb_s_q  <= '0;
            lid_s_q   <= '0;
            deb_cnt_q <= '0;
            tmo_cnt_q <= '0;
            credit_q  <= '0;
            l_q       <= 1'b1;
            dw_q      <= 1'b0;
            c_q       <= 1'b0;
            busy_q    <= 1'b0;
            refund_q  <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            coin_s_q  <= {coin_s_q[1:0], COIN_IN};
            dwb_s_q   <= {dwb_s_q[1:0], DW_BTN};
            refb_s_q  <= {refb_s_q[1:0], REFUND_BTN};
            lid_s_q   <= {lid_s_q[0], LID_SW};
            deb_cnt_q <= deb_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            credit_q  <= credit_d;
            l_q       <= l_d;
            dw_q      <= dw_d;
            c_q       <= c_d;
            busy_q    <= busy_d;
            refund_q  <= refund_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        l_d       = l_q;
        deb_cnt_d = '0;
        if (lid_s_q[1] != l_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                l_d = lid_s_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + 4'd1;
            end
        end
    end

    // Start is decided on the next credit so C rises on the edge the last coin lands
    always_comb begin
        state_d = state_q;
        case (state_q)
            P_COLLECT: if (credit_d == PRICE_C && !l_q) state_d = P_START;
            P_START: begin
                if (LAMPS[1])                    state_d = P_RUN;
                else if (l_q)                    state_d = P_COLLECT;
                else if (tmo_cnt_q == TMO_LAST)  state_d = P_COLLECT;
            end
            P_RUN:     if (LAMPS[0]) state_d = P_COLLECT;
            default:   state_d = P_COLLECT;
        endcase
    end

    always_comb begin
        credit_d  = credit_q;
        dw_d      = dw_q;
        refund_d  = 1'b0;
        done_d    = 1'b0;
        fault_d   = 1'b0;
        tmo_cnt_d = '0;
        case (state_q)
            P_COLLECT: begin
                if (ref_edge) begin
                    refund_d = 1'b1;
                    credit_d = '0;
                    dw_d     = 1'b0;
                end else begin
                    if (coin_edge) begin
                        if (credit_q == PRICE_C) refund_d = 1'b1;
                        else                     credit_d = credit_q + CW'(1);
                    end
                    if (dw_edge) dw_d = ~dw_q;
                end
            end
            P_START: begin
                refund_d  = coin_edge;
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if (LAMPS[1])                           credit_d = '0;
                else if (!l_q && tmo_cnt_q == TMO_LAST) fault_d  = 1'b1;
            end
            P_RUN: begin
                refund_d = coin_edge;
                if (LAMPS[0]) begin
                    done_d = 1'b1;
                    dw_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign c_d    = (state_d == P_START);
    assign busy_d = (state_d != P_COLLECT);

    assign C      = c_q;
    assign L      = l_q;
    assign DW     = dw_q;
    assign CREDIT = credit_q;
    assign BUSY   = busy_q;
    assign REFUND = refund_q;
    assign DONE   = done_q;
    assign FAULT  = fault_q;
endmodule
